// File: rtl/axil_reg_access_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite register access arbiter.
package axil_reg_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG0 = 4'h0;
  localparam logic [3:0] REG1 = 4'h4;
  localparam logic [3:0] REG2 = 4'h8;
  localparam logic [3:0] REG3 = 4'hC;

endpackage

// File: rtl/axil_reg_access_arbiter_if.sv
// AXI4-Lite bus between the arbiter (master) and the PL_registers slave.
interface axil_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid,
           m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid,
           m_arready, m_rdata, m_rresp, m_rvalid
  );
endinterface

// File: rtl/axil_reg_access_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a tie goes to the requester that was not granted last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_valid,
  output logic       grant_idx
);
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant_valid  = |req;
    grant_idx    = (req == 2'b11) ? ~last_grant_q : req[1];
    last_grant_d = last_grant_q;
    if (update && grant_valid) last_grant_d = grant_idx;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/axil_reg_access_arbiter.sv
// Serialises register accesses from two req/ack ports onto one AXI4-Lite master, one transaction at a time.
module axil_reg_access_arbiter
  import axil_reg_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int NREQ   = 2
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  input  logic [NREQ*4-1:0]      req_wstrb,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [1:0]             rsp_resp,
  axil_if.master                 m
);
  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;

  logic              grant_valid, grant_idx, arb_update;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_wstrb;
  logic              aw_done, w_done;

  rr_arbiter2 u_arb (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .req         (req),
    .update      (arb_update),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_we    = grant_idx ? req_we[1] : req_we[0];
  assign sel_addr  = grant_idx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign sel_wdata = grant_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign sel_wstrb = grant_idx ? req_wstrb[7:4] : req_wstrb[3:0];

  // AW and W complete independently; a channel is done once its valid has been accepted.
  assign aw_done = !awvalid_q || m.m_awready;
  assign w_done  = !wvalid_q  || m.m_wready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    arb_update = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          arb_update = 1'b1;
          grant_d    = grant_idx;
          addr_d     = {sel_addr[ADDR_W-1:2], 2'b00};
          wdata_d    = sel_wdata;
          wstrb_d    = sel_wstrb;
          if (sel_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        if (awvalid_q && m.m_awready) awvalid_d = 1'b0;
        if (wvalid_q && m.m_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (m.m_bvalid) begin
          resp_d         = m.m_bresp;
          bready_d       = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end
      end
      RD_AR: begin
        if (m.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (m.m_rvalid) begin
          rdata_d        = m.m_rdata;
          resp_d         = m.m_rresp;
          rready_d       = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  assign m.m_awaddr  = addr_q;
  assign m.m_araddr  = addr_q;
  assign m.m_wdata   = wdata_q;
  assign m.m_wstrb   = wstrb_q;
  assign m.m_awvalid = awvalid_q;
  assign m.m_wvalid  = wvalid_q;
  assign m.m_bready  = bready_q;
  assign m.m_arvalid = arvalid_q;
  assign m.m_rready  = rready_q;
  assign ack         = ack_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
endmodule

// File: tb/tb_axil_reg_access_arbiter.sv
// Bench for axil_reg_access_arbiter: reactive AXI-Lite slave, two requester drivers and a register-file model.
module tb_axil_reg_access_arbiter;
  import axil_reg_arb_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic [1:0]  req = '0, req_we = '0;
  logic [7:0]  req_addr = '0, req_wstrb = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  ack, rsp_resp;
  logic [31:0] rsp_rdata;

  always #5 ACLK = ~ACLK;

  axil_if #(.ADDR_W(4), .DATA_W(32)) m ();

  axil_reg_access_arbiter #(.ADDR_W(4), .DATA_W(32), .NREQ(2)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .ack(ack), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .m(m)
  );

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } op_t;

  op_t q0[$], q1[$];
  int errors = 0, checks = 0;
  int cyc = 0, ack_n = 0, aw_hs_n = 0, w_hs_n = 0, proto_err = 0, b_hs_cyc = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  cfg_rresp = RESP_OKAY;
  logic [31:0] mem [4];
  logic [31:0] model_mem [4];
  logic [31:0] model_rdata = '0;
  logic [1:0]  last_resp = '0;
  int idx_log[$], cyc_log[$], lat_log[$];
  logic [31:0] rd_log[$];
  int raise_cyc [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d; o.wstrb = s;
    return o;
  endfunction

  // Model: completions are applied in ack order to a plain four-word register file.
  task automatic complete(input int i);
    op_t o;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
    int sz;
    sz = (i == 0) ? q0.size() : q1.size();
    chk("ack_pending", 32'(sz > 0), 1);
    if (sz > 0) begin
      if (i == 0) o = q0.pop_front(); else o = q1.pop_front();
      if (o.we) begin
        for (int b = 0; b < 4; b++)
          if (o.wstrb[b]) model_mem[o.addr[3:2]][8*b +: 8] = o.wdata[8*b +: 8];
        exp_rd   = model_rdata;
        exp_resp = RESP_OKAY;
      end else begin
        exp_rd   = model_mem[o.addr[3:2]];
        exp_resp = cfg_rresp;
      end
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
      model_rdata = exp_rd;
      if (!o.we) rd_log.push_back(rsp_rdata);
      last_resp = rsp_resp;
      idx_log.push_back(i);
      cyc_log.push_back(cyc);
      lat_log.push_back(cyc - raise_cyc[i]);
    end
    ack_n++;
    req[i] = 1'b0;
  endtask

  // Slave, monitor and requester drivers, all evaluated on the falling edge.
  initial begin
    logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
    logic [3:0]  p_awaddr, p_araddr, p_wstrb, aw_a, r_a;
    logic [31:0] p_wdata, w_d;
    logic [3:0]  w_s;
    logic aw_got, w_got, b_pend, r_pend;
    int aw_c, w_c, b_c, ar_c, r_c, sz;
    {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
    {aw_got, w_got, b_pend, r_pend} = '0;
    p_awaddr = '0; p_araddr = '0; p_wstrb = '0; p_wdata = '0;
    aw_a = '0; r_a = '0; w_d = '0; w_s = '0;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    m.m_awready = 0; m.m_wready = 0; m.m_bvalid = 0; m.m_bresp = RESP_OKAY;
    m.m_arready = 0; m.m_rvalid = 0; m.m_rdata = '0; m.m_rresp = RESP_OKAY;
    for (int k = 0; k < 4; k++) begin mem[k] = '0; model_mem[k] = '0; end
    forever begin
      @(negedge ACLK);
      cyc++;
      if (!ARESETN) begin
        m.m_awready = 0; m.m_wready = 0; m.m_bvalid = 0; m.m_arready = 0; m.m_rvalid = 0;
        {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
        {aw_got, w_got, b_pend, r_pend} = '0;
        aw_c = 0; w_c = 0; ar_c = 0;
      end else begin
        if (p_awv && !p_awr && (!m.m_awvalid || m.m_awaddr != p_awaddr)) proto_err++;
        if (p_wv && !p_wr && (!m.m_wvalid || m.m_wdata != p_wdata || m.m_wstrb != p_wstrb)) proto_err++;
        if (p_arv && !p_arr && (!m.m_arvalid || m.m_araddr != p_araddr)) proto_err++;
        if ((m.m_awvalid && m.m_awaddr[1:0] != 2'b00) || (m.m_arvalid && m.m_araddr[1:0] != 2'b00)) proto_err++;
        if (p_bv && p_br) begin m.m_bvalid = 0; b_pend = 0; b_hs_cyc = cyc - 1; end
        if (p_awv && p_awr) begin aw_got = 1; aw_hs_n++; aw_a = p_awaddr; end
        if (p_wv && p_wr) begin w_got = 1; w_hs_n++; w_d = p_wdata; w_s = p_wstrb; end
        if (aw_got && w_got) begin
          for (int b = 0; b < 4; b++) if (w_s[b]) mem[aw_a[3:2]][8*b +: 8] = w_d[8*b +: 8];
          aw_got = 0; w_got = 0; b_pend = 1; b_c = 0;
        end
        if (b_pend && !m.m_bvalid) begin
          if (b_c >= b_dly) m.m_bvalid = 1; else b_c++;
        end
        if (p_rv && p_rr) begin m.m_rvalid = 0; r_pend = 0; end
        if (p_arv && p_arr) begin r_pend = 1; r_c = 0; r_a = p_araddr; end
        if (r_pend && !m.m_rvalid) begin
          if (r_c >= r_dly) begin
            m.m_rvalid = 1; m.m_rdata = mem[r_a[3:2]]; m.m_rresp = cfg_rresp;
          end else r_c++;
        end
        if (m.m_awvalid && !aw_got) begin m.m_awready = (aw_c >= aw_dly); aw_c++; end
        else begin m.m_awready = 0; aw_c = 0; end
        if (m.m_wvalid && !w_got) begin m.m_wready = (w_c >= w_dly); w_c++; end
        else begin m.m_wready = 0; w_c = 0; end
        if (m.m_arvalid) begin m.m_arready = (ar_c >= ar_dly); ar_c++; end
        else begin m.m_arready = 0; ar_c = 0; end

        if (ack != 2'b00) chk("ack_onehot", $countones(ack), 1);
        for (int i = 0; i < 2; i++) if (ack[i]) complete(i);
        for (int i = 0; i < 2; i++) begin
          sz = (i == 0) ? q0.size() : q1.size();
          if (!req[i] && sz > 0) begin
            op_t o;
            if (i == 0) o = q0[0]; else o = q1[0];
            req_we[i]           = o.we;
            req_addr[i*4 +: 4]  = o.addr;
            req_wdata[i*32 +: 32] = o.wdata;
            req_wstrb[i*4 +: 4] = o.wstrb;
            req[i]              = 1'b1;
            raise_cyc[i]        = cyc;
          end
        end
        p_awv = m.m_awvalid; p_awr = m.m_awready; p_awaddr = m.m_awaddr;
        p_wv = m.m_wvalid; p_wr = m.m_wready; p_wdata = m.m_wdata; p_wstrb = m.m_wstrb;
        p_bv = m.m_bvalid; p_br = m.m_bready;
        p_arv = m.m_arvalid; p_arr = m.m_arready; p_araddr = m.m_araddr;
        p_rv = m.m_rvalid; p_rr = m.m_rready;
      end
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(posedge ACLK); n++;
    end
    chk(tag, q0.size() + q1.size(), 0);
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  task automatic reset_pulse();
    ARESETN = 1'b0;
    q0.delete(); q1.delete();
    req = '0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    model_rdata = '0;
    @(posedge ACLK); #1;
  endtask

  task automatic clear_logs();
    idx_log.delete(); cyc_log.delete(); lat_log.delete(); rd_log.delete();
  endtask

  function automatic logic [4:0] hs_vec();
    return {m.m_awvalid, m.m_wvalid, m.m_bready, m.m_arvalid, m.m_rready};
  endfunction

  initial begin
    int aw0, w0, n, n0;
    logic [31:0] d;
    #2 ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_handshakes", 32'(hs_vec()), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_resp", 32'(rsp_resp), 0);
    chk("rst_addr_data", {m.m_awaddr, m.m_araddr, m.m_wstrb}, 0);
    chk("rst_wdata", m.m_wdata, 0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Requester 0 writes 1..4 then reads them back.
    clear_logs();
    q0.push_back(mk(1, REG0, 32'd1, 4'hF));
    q0.push_back(mk(1, REG1, 32'd2, 4'hF));
    q0.push_back(mk(1, REG2, 32'd3, 4'hF));
    q0.push_back(mk(1, REG3, 32'd4, 4'hF));
    q0.push_back(mk(0, REG0, '0, '0));
    q0.push_back(mk(0, REG1, '0, '0));
    q0.push_back(mk(0, REG2, '0, '0));
    q0.push_back(mk(0, REG3, '0, '0));
    wait_idle("t1_timeout", 200);
    chk("t1_nreads", rd_log.size(), 4);
    for (int k = 0; k < 4 && k < rd_log.size(); k++) chk("t1_readback", rd_log[k], 32'(k + 1));
    if (lat_log.size() >= 2) begin
      chk("t1_first_latency", lat_log[0], 3);
      chk("t1_b2b_latency", lat_log[1], 4);
    end

    // Simultaneous requests after reset alternate 0,1,0,1,0,1.
    reset_pulse();
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      q0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom)));
      q1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom)));
    end
    wait_idle("t2_timeout", 200);
    chk("t2_nacks", idx_log.size(), 6);
    for (int k = 0; k < 6 && k < idx_log.size(); k++) chk("t2_grant_order", idx_log[k], k % 2);
    for (int k = 1; k < 6 && k < cyc_log.size(); k++) chk("t2_grant_spacing", cyc_log[k] - cyc_log[k-1], 4);

    // AW accepted 3 cycles before W, B two cycles after W.
    clear_logs();
    aw_dly = 0; w_dly = 3; b_dly = 2;
    aw0 = aw_hs_n; w0 = w_hs_n;
    q1.push_back(mk(1, REG2, 32'h1234_5678, 4'hF));
    wait_idle("t3_timeout", 200);
    chk("t3_aw_count", aw_hs_n - aw0, 1);
    chk("t3_w_count", w_hs_n - w0, 1);
    if (cyc_log.size() == 1) chk("t3_ack_after_b", cyc_log[0] - b_hs_cyc, 1);
    w_dly = 0; b_dly = 0;

    // Partial-strobe write merges into the existing word.
    clear_logs();
    q0.push_back(mk(1, REG1, 32'hDEAD_BEEF, 4'hF));
    q0.push_back(mk(1, REG1, 32'h0000_CAFE, 4'b0011));
    q0.push_back(mk(0, REG1, '0, '0));
    wait_idle("t4_timeout", 200);
    if (rd_log.size() == 1) chk("t4_strobe_merge", rd_log[0], 32'hDEAD_CAFE);

    // SLVERR on read passes through, next write completes OKAY.
    cfg_rresp = RESP_SLVERR;
    q0.push_back(mk(0, REG2, '0, '0));
    wait_idle("t5_timeout", 200);
    chk("t5_slverr", 32'(last_resp), 32'(RESP_SLVERR));
    cfg_rresp = RESP_OKAY;
    q0.push_back(mk(1, REG2, 32'hA5A5_0F0F, 4'hF));
    wait_idle("t5b_timeout", 200);
    chk("t5_write_okay", 32'(last_resp), 32'(RESP_OKAY));

    // Reset while waiting for BVALID: no ack, everything idles, first tie goes to 0.
    b_dly = 20;
    n0 = ack_n;
    q1.push_back(mk(1, REG3, model_mem[3], 4'hF));
    n = 0;
    while (!m.m_bready && n < 50) begin @(posedge ACLK); #1; n++; end
    chk("t6_in_wr_b", 32'(m.m_bready), 1);
    ARESETN = 1'b0;
    q0.delete(); q1.delete();
    req = '0;
    #1;
    chk("t6_rst_handshakes", 32'(hs_vec()), 0);
    repeat (2) @(posedge ACLK);
    #1;
    chk("t6_rst_hold", 32'(hs_vec()), 0);
    chk("t6_rst_ack", 32'(ack), 0);
    ARESETN = 1'b1;
    model_rdata = '0;
    b_dly = 0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("t6_no_ack", ack_n - n0, 0);
    clear_logs();
    q0.push_back(mk(0, REG0, '0, '0));
    q1.push_back(mk(0, REG3, '0, '0));
    wait_idle("t6_timeout", 200);
    if (idx_log.size() == 2) begin
      chk("t6_post_rst_tie0", idx_log[0], 0);
      chk("t6_post_rst_tie1", idx_log[1], 1);
    end

    // Randomised traffic from both requesters with random slave stalls.
    for (int batch = 0; batch < 4; batch++) begin
      aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2); b_dly = $urandom_range(0, 2);
      ar_dly = $urandom_range(0, 2); r_dly = $urandom_range(0, 2);
      for (int k = 0; k < 10; k++) begin
        d = $urandom;
        if ($urandom_range(0, 1) == 1) q0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom), d, 4'($urandom)));
        else                           q1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom), d, 4'($urandom)));
      end
      wait_idle("t7_timeout", 1000);
    end

    chk("axi_protocol", proto_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
